// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Single-outstanding instruction fetcher. A program counter drives fetch
// requests to instruction memory; each returned word is presented to decode
// together with the address it was fetched from. Branch/jump redirects
// replace the program counter and squash any fetch that is still in flight.
//
// Parameters
//   RESET_PC        first fetch address after reset
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst_n           asynchronous active-low reset
//   req_valid       fetch request valid (out)
//   req_addr[31:0]  fetch address, word aligned (out)
//   req_ready       memory accepts the request (in)
//   rsp_valid       memory returns a fetched word (in)
//   rsp_data[31:0]  fetched instruction word (in)
//   redirect_valid  branch/jump redirect strobe (in)
//   redirect_target redirect address, low two bits ignored (in)
//   instr_valid     instruction available to decode (out)
//   instr[31:0]     instruction word (out)
//   instr_pc[31:0]  address of instr (out)
//   instr_ready     decode consumes instr (in)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    // REQ: may issue a fetch. WAIT: a fetch is outstanding and its response
    // is wanted. DROP: a fetch is outstanding but its response is stale.
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  state_r;
    logic [31:0] pc_r;
    logic [31:0] inflight_pc_r;
    logic        instr_valid_r;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;

    logic        req_valid_s;
    logic        req_fire_s;
    logic        consume_s;
    logic [31:0] redirect_pc_s;

    // Request only from REQ, and only when the output slot is free or being
    // drained this cycle, so at most one word is ever outstanding.
    always_comb begin
        req_valid_s = 1'b0;
        case (state_r)
            ST_REQ:  req_valid_s = (!instr_valid_r) || instr_ready;
            default: req_valid_s = 1'b0;
        endcase
    end

    assign req_fire_s    = req_valid_s && req_ready;
    assign consume_s     = instr_valid_r && instr_ready;
    assign redirect_pc_s = {redirect_target[31:2], 2'b00};

    assign req_valid   = req_valid_s;
    assign req_addr    = pc_r;
    assign instr_valid = instr_valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;

    // Fetch sequencing: redirect beats both response capture and pc increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_REQ;
            pc_r          <= RESET_PC;
            inflight_pc_r <= 32'h00000000;
            instr_valid_r <= 1'b0;
            instr_r       <= 32'h00000000;
            instr_pc_r    <= 32'h00000000;
        end else if (redirect_valid) begin
            pc_r          <= redirect_pc_s;
            instr_valid_r <= 1'b0;
            case (state_r)
                ST_REQ: begin
                    // A request accepted this edge is now stale: drain it.
                    if (req_fire_s) begin
                        inflight_pc_r <= pc_r;
                        state_r       <= ST_DROP;
                    end else begin
                        state_r       <= ST_REQ;
                    end
                end
                // A response arriving with the redirect is simply discarded.
                ST_WAIT: state_r <= rsp_valid ? ST_REQ : ST_DROP;
                ST_DROP: state_r <= ST_DROP;
                default: state_r <= ST_REQ;
            endcase
        end else begin
            case (state_r)
                ST_REQ: begin
                    // rsp_valid is meaningless here and is ignored.
                    if (consume_s) begin
                        instr_valid_r <= 1'b0;
                    end
                    if (req_fire_s) begin
                        inflight_pc_r <= pc_r;
                        pc_r          <= pc_r + 32'd4;
                        state_r       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid) begin
                        instr_r       <= rsp_data;
                        instr_pc_r    <= inflight_pc_r;
                        instr_valid_r <= 1'b1;
                        state_r       <= ST_REQ;
                    end else if (consume_s) begin
                        instr_valid_r <= 1'b0;
                    end
                end
                ST_DROP: begin
                    if (consume_s) begin
                        instr_valid_r <= 1'b0;
                    end
                    if (rsp_valid) begin
                        state_r <= ST_REQ;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean fetch state.
                    state_r       <= ST_REQ;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        instr_ready = 1'b0;

    logic        req_valid, instr_valid;
    logic [31:0] req_addr, instr, instr_pc;
    logic        w_req_valid, w_instr_valid;
    logic [31:0] w_req_addr, w_instr, w_instr_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h00000000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_addr(w_req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_ready(instr_ready)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_target = 32'h0; instr_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_instr_valid got %0b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_cmp++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL rel_req_valid got %0b want 1", req_valid); end
        n_cmp++; if (req_addr !== 32'h0) begin n_err++; $display("FAIL rel_req_addr got %h want 0", req_addr); end
        n_cmp++; if (w_req_addr !== 32'hFFFFFFFC) begin n_err++; $display("FAIL rel_wrap_addr got %h want fffffffc", w_req_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc, acc_addr;
        logic        acc;
        int          got, gap;
        do_reset();
        req_ready = 1'b1; instr_ready = 1'b1;
        exp_pc = 32'h0; got = 0; gap = 0; acc = 1'b0; acc_addr = 32'h0;
        #1;
        for (int c = 0; c < 30 && got < 3; c++) begin
            if (instr_valid === 1'b1) begin
                n_cmp++; if (instr_pc !== exp_pc) begin n_err++; $display("FAIL seq_pc got %h want %h", instr_pc, exp_pc); end
                n_cmp++; if (instr !== (32'hA0 + exp_pc)) begin n_err++; $display("FAIL seq_instr got %h want %h", instr, 32'hA0 + exp_pc); end
                n_cmp++; if (gap > 3) begin n_err++; $display("FAIL seq_gap got %0d want <=3", gap); end
                exp_pc = exp_pc + 32'd4; got++; gap = 0;
            end else begin
                gap++;
            end
            acc = req_valid && req_ready; acc_addr = req_addr;
            tick();
            rsp_valid = acc; rsp_data = 32'hA0 + acc_addr;
            #1;
        end
        rsp_valid = 1'b0;
        n_cmp++; if (got != 3) begin n_err++; $display("FAIL seq_count got %0d want 3", got); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_ready = 1'b1; instr_ready = 1'b0;
        tick();                                  // addr 0 accepted
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD0000;
        tick();                                  // word captured
        rsp_valid = 1'b0; req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL bp_req_valid got %0b want 0", req_valid); end
            n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hDEAD0000 || instr_pc !== 32'h0) begin
                n_err++; $display("FAIL bp_hold got v=%0b %h@%h want 1 dead0000@0", instr_valid, instr, instr_pc); end
            tick();
        end
        instr_ready = 1'b1;
        #1;
        n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h4) begin
            n_err++; $display("FAIL bp_release got v=%0b a=%h want 1 00000004", req_valid, req_addr); end
        tick();
        req_ready = 1'b0; instr_ready = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL bp_consumed got %0b want 0", instr_valid); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h12;
        tick();                                  // redirect in REQ, no handshake
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h10) begin
            n_err++; $display("FAIL rdq_addr got v=%0b a=%h want 1 00000010", req_valid, req_addr); end
        req_ready = 1'b1;
        tick();                                  // 0x10 outstanding
        req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h103;
        tick();                                  // -> DROP
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (req_valid !== 1'b0 || req_addr !== 32'h100) begin
            n_err++; $display("FAIL rdw_drop got v=%0b a=%h want 0 00000100", req_valid, req_addr); end
        rsp_valid = 1'b1; rsp_data = 32'h00000BAD;
        tick();                                  // stale word discarded
        rsp_valid = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rdw_discard got %0b want 0", instr_valid); end
        n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin
            n_err++; $display("FAIL rdw_next got v=%0b a=%h want 1 00000100", req_valid, req_addr); end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h55555555; instr_ready = 1'b0;
        tick();
        rsp_valid = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h55555555) begin
            n_err++; $display("FAIL rdw_deliver got v=%0b %h@%h want 1 55555555@00000100", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        instr_ready = 1'b1; req_ready = 1'b1;
        tick();                                  // addr 0 outstanding
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'h12345678;
        redirect_valid = 1'b1; redirect_target = 32'h200;
        tick();
        rsp_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rdr_valid got %0b want 0", instr_valid); end
        n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h200) begin
            n_err++; $display("FAIL rdr_next got v=%0b a=%h want 1 00000200", req_valid, req_addr); end
    endtask

    task automatic test_redirect_handshake();
        do_reset();
        instr_ready = 1'b1; req_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h301;
        tick();                                  // handshake + redirect -> DROP
        redirect_valid = 1'b0; req_ready = 1'b0;
        #1;
        n_cmp++; if (req_valid !== 1'b0 || req_addr !== 32'h300) begin
            n_err++; $display("FAIL rdh_drop got v=%0b a=%h want 0 00000300", req_valid, req_addr); end
        rsp_valid = 1'b1; rsp_data = 32'hCAFEF00D;
        tick();
        rsp_valid = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || req_valid !== 1'b1) begin
            n_err++; $display("FAIL rdh_after got iv=%0b rv=%0b want 0 1", instr_valid, req_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        #1;
        n_cmp++; if (w_req_addr !== 32'hFFFFFFFC || w_req_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_first got v=%0b a=%h want 1 fffffffc", w_req_valid, w_req_addr); end
        req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        #1;
        n_cmp++; if (w_req_addr !== 32'h00000000) begin n_err++; $display("FAIL wrap_next got %h want 00000000", w_req_addr); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        req_ready = 1'b1;
        tick();                                  // addr 0 outstanding
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h00000077;
        tick();                                  // word at 0 captured
        rsp_valid = 1'b0; instr_ready = 1'b1; req_ready = 1'b1;
        tick();                                  // consumed, addr 4 outstanding
        req_ready = 1'b0; instr_ready = 1'b0;
        #1;
        n_cmp++; if (instr !== 32'h77 || req_addr !== 32'h8 || req_valid !== 1'b0) begin
            n_err++; $display("FAIL rmw_pre got i=%h a=%h v=%0b want 00000077 00000008 0", instr, req_addr, req_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (instr !== 32'h0 || instr_valid !== 1'b0 || instr_pc !== 32'h0 || req_addr !== 32'h0) begin
            n_err++; $display("FAIL rmw_async got i=%h v=%0b pc=%h a=%h want all 0", instr, instr_valid, instr_pc, req_addr); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_valid = 1'b1; rsp_data = 32'h0BADBAD0;
        #1;
        n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
            n_err++; $display("FAIL rmw_release got v=%0b a=%h want 1 00000000", req_valid, req_addr); end
        tick();
        rsp_valid = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin
            n_err++; $display("FAIL rmw_stale got v=%0b i=%h want 0 00000000", instr_valid, instr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp();
        test_redirect_handshake();
        test_wrap();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, output, 1, instruction-memory fetch request valid.
REQ-005 The block SHALL have port req_addr, output, 32, fetch address (word aligned).
REQ-006 The block SHALL have port req_ready, input, 1, memory accepts the request.
REQ-007 The block SHALL have port rsp_valid, input, 1, memory returns a fetched word.
REQ-008 The block SHALL have port rsp_data, input, 32, fetched instruction word.
REQ-009 The block SHALL have port redirect_valid, input, 1, branch/jump redirect strobe.
REQ-010 The block SHALL have port redirect_target, input, 32, redirect address.
REQ-011 The block SHALL have port instr_valid, output, 1, instruction available to decode.
REQ-012 The block SHALL have port instr, output, 32, instruction word.
REQ-013 The block SHALL have port instr_pc, output, 32, address of instr.
REQ-014 The block SHALL have port instr_ready, input, 1, decode consumes instr.

Function
REQ-015 The block SHALL hold a 32-bit pc register and a 32-bit inflight_pc register, and an FSM with states REQ, WAIT, DROP.
REQ-016 In REQ, req_valid SHALL equal (!instr_valid || instr_ready); req_addr SHALL equal pc in every state.
REQ-017 A request SHALL be accepted on req_valid && req_ready: inflight_pc <= pc, pc <= pc + 4 (modulo 2^32), state -> WAIT.
REQ-018 pc 32'hFFFFFFFC plus 4 SHALL wrap to 32'h00000000 with no flag.
REQ-019 In WAIT and DROP, req_valid SHALL be 0; at most one request SHALL be outstanding.
REQ-020 In WAIT, on rsp_valid: instr <= rsp_data, instr_pc <= inflight_pc, instr_valid <= 1, state -> REQ; response-to-output latency one cycle.
REQ-021 instr_valid SHALL stay high with instr/instr_pc stable until the cycle instr_ready is high; it SHALL then clear unless a new response loads the same edge.
REQ-022 rsp_valid in REQ SHALL be ignored.
REQ-023 On redirect_valid in any state: pc <= {redirect_target[31:2], 2'b00}, instr_valid <= 0; redirect SHALL take priority over response capture and pc increment.
REQ-024 Redirect in WAIT without rsp_valid, or in REQ coinciding with a request handshake, SHALL move to DROP; redirect in WAIT with rsp_valid SHALL discard that response and go to REQ.
REQ-025 In DROP, rsp_valid SHALL be discarded (no output change) and state -> REQ; redirect in DROP SHALL update pc and remain in DROP.
REQ-026 Redirect in REQ without handshake SHALL remain in REQ; next req_addr SHALL be the aligned target.

Reset
REQ-027 While rst_n is 0 (asynchronously): pc = RESET_PC, inflight_pc = 0, state = REQ, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-028 Reset asserted mid-transaction SHALL abandon any outstanding request; a late rsp_valid after reset release SHALL be ignored in REQ.
REQ-029 The first cycle after release SHALL show req_valid = 1, req_addr = RESET_PC.

Verification
REQ-030 Sequential fetch: req_ready = 1, memory answers one cycle later with 32'hA0+addr -> instr_pc 0,4,8 in order with matching instr, no gaps beyond 3 cycles each.
REQ-031 Backpressure: instr_ready = 0 with instr_valid = 1 -> req_valid = 0, instr/instr_pc frozen; raise instr_ready -> next request issued same cycle.
REQ-032 Redirect in WAIT: request at 32'h10 outstanding, redirect to 32'h103 -> DROP, response discarded, next req_addr = 32'h100, instr_pc = 32'h100 delivered.
REQ-033 Redirect coincident with response: rsp_valid and redirect_valid same cycle -> instr_valid stays 0, next req_addr = redirect target.
REQ-034 Wrap: RESET_PC = 32'hFFFFFFFC -> req_addr FFFFFFFC then 00000000.
REQ-035 Reset mid-WAIT: drop rst_n while waiting -> outputs zero immediately, req_addr = RESET_PC after release, stale rsp_valid ignored.
